// File: rtl/handshake_fifo_buffer_if.sv
// Handshake channel bundle for handshake_fifo_buffer: an upstream (ins) and a downstream (outs) port.
// A token moves on a side only at a rising clk edge where both its valid and its ready are high.
interface handshake_fifo_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;

  // master: the environment around the buffer (producer + consumer)
  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

  // slave: the buffer itself
  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );
endinterface

// File: rtl/handshake_fifo_buffer.sv
// Elastic in-order FIFO buffer on a handshake channel; the ready path is fully registered.
// Optional feature macro: HANDSHAKE_FIFO_BYPASS_EN (zero-latency pass-through when empty).
module handshake_fifo_buffer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_SLOTS  = 4,
  localparam int PTR_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int CNT_W      = $clog2(NUM_SLOTS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  handshake_fifo_buffer_if.slave    hs,
  output logic [CNT_W-1:0]          o_count,
  output logic [PTR_W-1:0]          o_rd_ptr,
  output logic [PTR_W-1:0]          o_wr_ptr
);

  logic [DATA_WIDTH-1:0] r_mem [NUM_SLOTS];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_ins_ready;

  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_bypass;
  logic                  w_store;
  logic                  w_deq;
  logic [CNT_W-1:0]      w_count_nxt;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NUM_SLOTS - 1)) next_ptr = '0;
    else                            next_ptr = p + PTR_W'(1);
  endfunction

  assign w_empty = (r_count == '0);

  always_comb begin
    hs.outs_valid = 1'b0;
    hs.outs       = '0;
    w_bypass      = 1'b0;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
    // r_ins_ready gates the pass-through so nothing leaks out while in or just after reset.
    if (w_empty) begin
      hs.outs_valid = hs.ins_valid & r_ins_ready;
      hs.outs       = r_ins_ready ? hs.ins : '0;
      w_bypass      = hs.ins_valid & r_ins_ready & hs.outs_ready;
    end else begin
      hs.outs_valid = 1'b1;
      hs.outs       = r_mem[r_rd_ptr];
    end
`else
    if (!w_empty) begin
      hs.outs_valid = 1'b1;
      hs.outs       = r_mem[r_rd_ptr];
    end
`endif
  end

  assign hs.ins_ready = r_ins_ready;
  assign w_push       = hs.ins_valid & r_ins_ready;
  assign w_pop        = hs.outs_valid & hs.outs_ready;
  // A bypassed token is both pushed and popped but never touches storage.
  assign w_store      = w_push & ~w_bypass;
  assign w_deq        = w_pop & ~w_bypass;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_store, w_deq})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_ins_ready <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      // Registered copy of (count != NUM_SLOTS); low during reset, rises one edge after release.
      r_ins_ready <= (w_count_nxt != CNT_W'(NUM_SLOTS));
      if (w_store) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_deq)   r_rd_ptr <= next_ptr(r_rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr_ptr] <= hs.ins;
  end

  assign o_count  = r_count;
  assign o_rd_ptr = r_rd_ptr;
  assign o_wr_ptr = r_wr_ptr;

endmodule
